// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit cores: FSM states, register
// addresses, status bit positions and the oversampling divider.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    localparam logic [3:0] UART_ADDR_DATA = 4'd0;
    localparam logic [3:0] UART_ADDR_STAT = 4'd1;

    localparam int STAT_NEMPTY = 0;
    localparam int STAT_OVR    = 1;
    localparam int STAT_FERR   = 2;
    localparam int STAT_FULL   = 3;

    // Clock cycles per 16x oversampling tick, rounded to nearest.
    function automatic int uart_div(input int clk_freq, input int baud_rate);
        return (clk_freq + 8 * baud_rate) / (16 * baud_rate);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with extra pointer wrap bit for full/empty; a push
// while full is accepted only when a pop frees the slot in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       arst_n_i,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with Avalon-MM register access. UART_RX_FIFO_EN selects a
// FIFO_DEPTH-entry FIFO; otherwise a single holding register buffers bytes.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | line idle, waiting for a falling edge
// ST_START | start bit; confirm low at mid-bit or drop as a glitch
// ST_DATA  | sample 8 data bits at mid-bit, LSB first
// ST_STOP  | sample stop bit; push byte or flag framing error
// ST_BREAK | framing error seen, wait for the line to return high
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       arst_n_i,
    input  logic [3:0] avms_address_i,
    input  logic       avms_read_i,
    input  logic       avms_write_i,
    input  logic [7:0] avms_writedata_i,
    output logic [7:0] avms_readdata_o,
    input  logic       uart_rxd_i,
    output logic       irq_o
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE);
    localparam int DW  = $clog2(DIV + 1);

    logic          rxd_meta;
    logic          rxd_sync;
    logic          rxd_prev;
    logic          fall;
    logic [DW-1:0] div_cnt;
    logic [3:0]    tick_idx;
    logic          tick;
    logic          samp;
    logic          start_det;
    rx_state_e     state;
    rx_state_e     state_nxt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          shift_en;
    logic          frame_push;
    logic          ferr_set;
    logic          buf_pop;
    logic          buf_full;
    logic          buf_empty;
    logic [7:0]    buf_rdata;
    logic          ovr;
    logic          ferr;
    logic          ovr_set;
    logic          stat_clr;
    logic [7:0]    stat;
    logic [7:0]    rd_mux;
    logic          wdata_unused;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd_i;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    assign fall      = rxd_prev & ~rxd_sync;
    assign start_det = (state == ST_IDLE) && fall;

    // Free-running tick timer, re-phased on each start edge so that
    // tick_idx 7 lands mid-bit.
    assign tick = (div_cnt == '0);
    assign samp = tick && (tick_idx == 4'd7);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            div_cnt  <= DW'(DIV - 1);
            tick_idx <= '0;
        end else if (start_det) begin
            div_cnt  <= DW'(DIV - 1);
            tick_idx <= '0;
        end else if (tick) begin
            div_cnt  <= DW'(DIV - 1);
            tick_idx <= tick_idx + 1'b1;
        end else begin
            div_cnt  <= div_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state <= state_nxt;
            if (start_det) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= {rxd_sync, shreg[7:1]};
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        shift_en   = 1'b0;
        frame_push = 1'b0;
        ferr_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall) state_nxt = ST_START;
            end
            ST_START: begin
                if (samp) state_nxt = rxd_sync ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (samp) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (samp) begin
                    if (rxd_sync) begin
                        frame_push = 1'b1;
                        state_nxt  = ST_IDLE;
                    end else begin
                        ferr_set   = 1'b1;
                        state_nxt  = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rxd_sync) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign buf_pop = avms_read_i && (avms_address_i == UART_ADDR_DATA) && !buf_empty;

`ifdef UART_RX_FIFO_EN
    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .push     (frame_push),
        .wdata    (shreg),
        .pop      (buf_pop),
        .rdata    (buf_rdata),
        .full     (buf_full),
        .empty    (buf_empty)
    );
`else
    localparam int fifo_depth_unused = FIFO_DEPTH;

    logic [7:0] hold_data;
    logic       hold_valid;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (frame_push && (!hold_valid || buf_pop)) begin
            hold_data  <= shreg;
            hold_valid <= 1'b1;
        end else if (buf_pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign buf_rdata = hold_data;
    assign buf_full  = hold_valid;
    assign buf_empty = !hold_valid;
`endif

    // A pop in the same cycle frees the slot, so that push is not an overrun.
    assign ovr_set  = frame_push && buf_full && !buf_pop;
    assign stat_clr = avms_write_i && (avms_address_i == UART_ADDR_STAT);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ovr  <= ovr_set  | (ovr  & ~(stat_clr & avms_writedata_i[STAT_OVR]));
            ferr <= ferr_set | (ferr & ~(stat_clr & avms_writedata_i[STAT_FERR]));
        end
    end

    assign wdata_unused = ^{avms_writedata_i[7:3], avms_writedata_i[0]};

    always_comb begin
        stat              = '0;
        stat[STAT_NEMPTY] = !buf_empty;
        stat[STAT_OVR]    = ovr;
        stat[STAT_FERR]   = ferr;
        stat[STAT_FULL]   = buf_full;
    end

    always_comb begin
        rd_mux = '0;
        case (avms_address_i)
            UART_ADDR_DATA: if (!buf_empty) rd_mux = buf_rdata;
            UART_ADDR_STAT: rd_mux = stat;
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            avms_readdata_o <= '0;
        end else if (avms_read_i) begin
            avms_readdata_o <= rd_mux;
        end
    end

    assign irq_o = !buf_empty;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: serial frames are driven from a byte-level
// model; register reads push expected data that a monitor checks one cycle later.
module tb_uart_rx_core;

    localparam int CLK_FREQ   = 64_000_000;
    localparam int BAUD       = 1_000_000;
    localparam int FIFO_DEPTH = 8;
    localparam int DIV        = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
    localparam int BIT        = 16 * DIV;
`ifdef UART_RX_FIFO_EN
    localparam int MDEPTH = FIFO_DEPTH;
`else
    localparam int MDEPTH = 1;
`endif

    logic       clk_i = 1'b0;
    logic       arst_n_i;
    logic [3:0] avms_address_i;
    logic       avms_read_i;
    logic       avms_write_i;
    logic [7:0] avms_writedata_i;
    logic [7:0] avms_readdata_o;
    logic       uart_rxd_i;
    logic       irq_o;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mq[$];
    bit         m_ovr;
    bit         m_ferr;
    logic [7:0] exp_q[$];
    string      name_q[$];

    uart_rx_core #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i            (clk_i),
        .arst_n_i         (arst_n_i),
        .avms_address_i   (avms_address_i),
        .avms_read_i      (avms_read_i),
        .avms_write_i     (avms_write_i),
        .avms_writedata_i (avms_writedata_i),
        .avms_readdata_o  (avms_readdata_o),
        .uart_rxd_i       (uart_rxd_i),
        .irq_o            (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_status();
        logic [7:0] s;
        s    = 8'h00;
        s[0] = (mq.size() != 0);
        s[1] = m_ovr;
        s[2] = m_ferr;
        s[3] = (mq.size() == MDEPTH);
        return s;
    endfunction

    task automatic model_frame(input logic [7:0] b, input bit ok);
        if (!ok)                   m_ferr = 1'b1;
        else if (mq.size() < MDEPTH) mq.push_back(b);
        else                       m_ovr = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Drives fr LSB first, one bit per BIT cycles, for ncyc cycles.
    task automatic send_bits(input logic [9:0] fr, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            uart_rxd_i = fr[c / BIT];
            @(negedge clk_i);
        end
        uart_rxd_i = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit ok);
        send_bits({ok, b, 1'b0}, 10 * BIT);
        model_frame(b, ok);
    endtask

    task automatic do_read(input logic [3:0] a, input string nm);
        logic [7:0] e;
        e = 8'h00;
        if (a == 4'd0) begin
            if (mq.size() != 0) e = mq.pop_front();
        end else if (a == 4'd1) begin
            e = m_status();
        end
        exp_q.push_back(e);
        name_q.push_back(nm);
        avms_address_i = a;
        avms_read_i    = 1'b1;
        @(negedge clk_i);
        avms_read_i    = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        avms_address_i   = a;
        avms_writedata_i = d;
        avms_write_i     = 1'b1;
        @(negedge clk_i);
        avms_write_i     = 1'b0;
        if (a == 4'd1) begin
            if (d[1]) m_ovr  = 1'b0;
            if (d[2]) m_ferr = 1'b0;
        end
        @(negedge clk_i);
    endtask

    task automatic check_irq(input string nm);
        check(nm, {7'b0, irq_o}, {7'b0, mq.size() != 0});
    endtask

    initial begin : monitor
        logic [7:0] e;
        string      nm;
        forever begin
            @(posedge clk_i);
            if (avms_read_i) begin
                @(negedge clk_i);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_read: got 0x%02h, expected no read", avms_readdata_o);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    check(nm, avms_readdata_o, e);
                end
            end
        end
    end

    initial begin : watchdog
        repeat (95_000) @(posedge clk_i);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] tx6 [6];
        logic [7:0] b;
        bit         ok;
        int         r;
        logic [3:0] a;

        tx6 = '{8'h17, 8'h99, 8'h87, 8'h37, 8'h57, 8'h47};
        arst_n_i = 1'b0;
        uart_rxd_i = 1'b1;
        avms_address_i = '0;
        avms_read_i = 1'b0;
        avms_write_i = 1'b0;
        avms_writedata_i = '0;
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        wait_cycles(3);
        check("reset_readdata", avms_readdata_o, 8'h00);
        check_irq("reset_irq");
        arst_n_i = 1'b1;
        wait_cycles(2);
        do_read(4'd1, "reset_status");

        // single byte
        send_frame(8'h17, 1'b1);
        check_irq("irq_after_0x17");
        do_read(4'd1, "status_one");
        do_read(4'd0, "data_0x17");
        do_read(4'd1, "status_empty");
        check_irq("irq_after_pop");
        do_read(4'd0, "read_empty");

        // back-to-back frames
        foreach (tx6[i]) send_frame(tx6[i], 1'b1);
        wait_cycles(4);
        foreach (tx6[i]) do_read(4'd0, "loop_data");
        do_read(4'd1, "loop_status");

        // overrun: depth + 1 frames, no reads
        for (int i = 0; i < MDEPTH + 1; i++) send_frame(8'h30 + 8'(i), 1'b1);
        do_read(4'd1, "ovr_status");
        for (int i = 0; i < MDEPTH; i++) do_read(4'd0, "ovr_data");
        do_read(4'd1, "ovr_status_drained");
        do_write(4'd1, 8'h02);
        do_read(4'd1, "ovr_cleared");

        // framing error then recovery
        send_frame(8'h5C, 1'b0);
        wait_cycles(BIT);
        do_read(4'd1, "ferr_status");
        check_irq("ferr_irq");
        send_frame(8'hA5, 1'b1);
        do_read(4'd1, "ferr_then_byte_status");
        do_read(4'd0, "data_0xA5");
        do_write(4'd1, 8'h04);
        do_read(4'd1, "ferr_cleared");

        // 200 ns glitch
        uart_rxd_i = 1'b0;
        wait_cycles(20);
        uart_rxd_i = 1'b1;
        wait_cycles(2 * BIT);
        do_read(4'd1, "glitch_status");
        check_irq("glitch_irq");

        // unmapped addresses
        do_write(4'd5, 8'hFF);
        do_read(4'd7, "unmapped_read");
        do_read(4'd1, "unmapped_write_status");

        // randomized frames, errors, reads and clears
        for (int f = 0; f < 30; f++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            send_frame(b, ok);
            check_irq("rand_irq");
            if (!ok) wait_cycles(BIT);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                    r = int'($urandom_range(0, 9));
                    a = (r < 5) ? 4'd0 : (r < 8) ? 4'd1 : 4'($urandom_range(2, 15));
                    do_read(a, "rand_read");
                end
                if ($urandom_range(0, 3) == 0) do_write(4'd1, 8'($urandom));
            end else if ($urandom_range(0, 1) == 1) begin
                wait_cycles(int'($urandom_range(1, BIT / 2)));
            end
        end
        while (mq.size() != 0) do_read(4'd0, "rand_drain");
        do_read(4'd1, "rand_final_status");
        do_write(4'd1, 8'h06);
        do_read(4'd1, "rand_cleared");

        // reset in the middle of bit 4
        send_frame(8'h5A, 1'b1);
        do_read(4'd0, "pre_reset_0x5A");
        send_bits({1'b1, 8'hC3, 1'b0}, 5 * BIT + BIT / 2);
        arst_n_i = 1'b0;
        wait_cycles(2);
        check("midframe_reset_readdata", avms_readdata_o, 8'h00);
        check_irq("midframe_reset_irq");
        mq.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        arst_n_i = 1'b1;
        wait_cycles(BIT);
        do_read(4'd1, "post_reset_status");
        send_frame(8'h3C, 1'b1);
        do_read(4'd1, "post_reset_status_byte");
        do_read(4'd0, "data_0x3C");

        wait_cycles(5);
        check("scoreboard_drain", 8'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

UART receiver with an Avalon-MM slave register interface. It is the receive-side counterpart of `uart_core`: it deserialises 8N1 frames from `uart_rxd_i` and buffers the bytes in a FIFO for the host. In loopback benches it consumes `uart_core`'s `uart_txd_o`. Register-level behaviour matches `uart_core` so that one host driver serves both.

## Interface
- `CLK_FREQ`, default 100_000_000: `clk_i` frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in bit/s.
- `FIFO_DEPTH`, default 8: receive FIFO entries; must be a power of two and ≥ 2.
- `clk_i`  in  1  system clock; the only clock in the block.
- `arst_n_i`  in  1  reset, asynchronous, active-low.
- `avms_address_i`  in  4  register address.
- `avms_read_i`  in  1  read strobe, one cycle per access.
- `avms_write_i`  in  1  write strobe, one cycle per access.
- `avms_writedata_i`  in  8  write data.
- `avms_readdata_o`  out  8  read data, registered.
- `uart_rxd_i`  in  1  serial input; idles high.
- `irq_o`  out  1  high while the FIFO is not empty.

## Operation
- Oversampling tick: `DIV = (CLK_FREQ + 8*BAUD_RATE) / (16*BAUD_RATE)`, which gives 54 at the defaults. The tick counter is free-running and restarts on start-edge detect.
- `uart_rxd_i` passes through a 2-FF synchroniser. Both flops reset to 1.
- FSM states:
  - IDLE: on a falling edge go to START.
  - START: at tick 7 (mid-bit), if the line is low go to DATA; if it is high, treat it as a glitch and return to IDLE.
  - DATA: sample every 16 ticks, 8 bits, LSB first.
  - STOP: sample at mid-bit. If the sample is 1, push the byte. If it is 0, set the framing error (`ferr`), discard the byte and go to BREAK.
  - BREAK: wait for the line to be high, then go to IDLE.
- Register map:
  - addr 0, read: FIFO head, with pop. Reading an empty FIFO returns 0x00 and does not pop.
  - addr 1, read: status. bit0 = FIFO not empty, bit1 = overrun (`ovr`), bit2 = `ferr`, bit3 = FIFO full, bits 7:4 = 0.
  - addr 1, write: write-1-to-clear `ovr` (bit1) and `ferr` (bit2).
  - Other addresses: reads return 0x00; writes are ignored.
- Push while full: the byte is dropped and `ovr` is set. `ovr` and `ferr` are sticky until cleared.
- Pop and push in the same cycle while full: both succeed and the count is unchanged. On the same cycle while empty, the read returns 0x00 and the pushed byte stays in the FIFO.
- Write-1-to-clear on the same cycle as a new error event: the set wins.
- Reset values:
  - `avms_readdata_o` = 0x00 and `irq_o` = 0.
  - FIFO empty; `ovr` = `ferr` = 0.
  - FSM in IDLE.
- Asserting reset mid-frame aborts the frame. After release the block resynchronises on the next falling edge. It captures no partial bytes.

## Timing
- Read latency is 1 cycle: `avms_readdata_o` is valid on the cycle after `avms_read_i`. It holds until the next read.
- A pop takes effect on the clock edge that registers the read data.
- A pushed byte is visible on status bit0 and `irq_o` 1 cycle after the stop-bit mid-sample.
- Start edge to push: 2 synchroniser cycles plus about 9.5 bit times (about 8210 cycles at the defaults).
- Each bit is sampled once, at tick 7 of 16 within the bit. No majority vote.
- Back-to-back frames are accepted: a start edge directly after the stop-bit sample is detected.

## Configuration
- Macro: `UART_RX_FIFO_EN`.
- Defined: a `FIFO_DEPTH`-entry FIFO as described above.
- Undefined: a single holding register, so the effective depth is 1 and `FIFO_DEPTH` is ignored. Full = valid. Overrun and simultaneous push/pop rules are unchanged.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, STOP, BREAK);
  - the register address constants `UART_ADDR_DATA` = 0 and `UART_ADDR_STAT` = 1;
  - the status bit indices;
  - the divider function shared with `uart_core`.
- Sub-module `uart_rx_fifo`: synchronous FIFO, pointer width `$clog2(FIFO_DEPTH)+1`, with `full`, `empty` and simultaneous push/pop handling. It is instantiated only when `UART_RX_FIFO_EN` is defined.

## Test plan
- Drive 0x17 at 115200 baud → `irq_o` rises; status reads 0x01; a data read returns 0x17; a following status read returns 0x00.
- Loopback from `uart_core` sending 0x17, 0x99, 0x87, 0x37, 0x57, 0x47 → six reads return the bytes in order; `ovr` = `ferr` = 0.
- Send FIFO_DEPTH+1 bytes (9) with no reads:
  - status reads 0x0B (not empty, `ovr`, full);
  - 8 reads return the first 8 bytes and the 9th is lost;
  - writing 0x02 to addr 1 clears `ovr`.
- Frame with the stop bit forced to 0 → status reads 0x04 and the FIFO is empty. Line high, then 0xA5 → 0xA5 is received.
- 200 ns low glitch on the idle line → no push and no error flags. Reset asserted mid-frame during bit 4 → all outputs 0 and the next clean frame 0x3C is received intact.
